// File: rtl/up_counter_pkg.sv
// Shared types for the up-counting timer: FSM state encoding.
package up_counter_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_t;

endpackage

// File: rtl/up_counter_timer_if.sv
// Control/status bundle of the up-counting timer; master drives controls, slave is the timer.
interface up_counter_timer_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic             stop;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] limit;
  logic             periodic;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             busy;
  logic             done;

  modport master (
    output start, stop, up, load, load_val, limit, periodic,
    input  count, tc, busy, done
  );

  modport slave (
    input  start, stop, up, load, load_val, limit, periodic,
    output count, tc, busy, done
  );
endinterface

// File: rtl/up_counter_prescaler.sv
// Clock-enable divider for the timer; only built when PRESCALE_EN is defined.
module up_counter_prescaler #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_q, pre_d;
  logic          term;

  assign term = (pre_q == PRE_LAST);
  assign tick = en && term;

  always_comb begin
    pre_d = pre_q;
    if (clr)     pre_d = '0;
    else if (en) pre_d = term ? '0 : pre_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) pre_q <= '0;
    else       pre_q <= pre_d;
  end
endmodule

// File: rtl/up_counter_timer.sv
// Loadable up-counting timer with one-shot/periodic terminal count.
// Optional prescaler on the count enable is built when PRESCALE_EN is defined.
module up_counter_timer
  import up_counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 4
) (
  input  logic                clk,
  input  logic                reset,
  up_counter_timer_if.slave   bus
);
  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             tick;

`ifdef PRESCALE_EN
  // Prescaler only advances while counting; any control pulse realigns it.
  up_counter_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clr   (bus.start | bus.load | bus.stop),
    .en    (bus.up && (state_q == RUN)),
    .tick  (tick)
  );
`else
  localparam int unused_prescale = PRESCALE;
  assign tick = bus.up;
`endif

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    tc_d    = 1'b0;
    if (bus.load) begin
      count_d = bus.load_val;
    end else if (bus.stop) begin
      state_d = IDLE;
    end else if (bus.start) begin
      state_d = RUN;
      count_d = '0;
    end else if (tick && (state_q == RUN)) begin
      if (count_q == bus.limit) begin
        tc_d = 1'b1;
        if (bus.periodic) count_d = '0;
        else              state_d = DONE;
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

  assign bus.count = count_q;
  assign bus.tc    = tc_q;
  assign bus.busy  = (state_q == RUN);
  assign bus.done  = (state_q == DONE);
endmodule

// File: tb/tb_up_counter_timer.sv
// Directed self-checking bench for up_counter_timer (prescaler scenario when PRESCALE_EN is defined).
module tb_up_counter_timer;
  localparam int W = 4;

  logic clk = 1'b0;
  logic reset;
  int   total  = 0;
  int   passed = 0;

  up_counter_timer_if #(.WIDTH(W)) bus();

  up_counter_timer #(.WIDTH(W), .PRESCALE(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.start = 1'b1; bus.stop = 1'b0; bus.up = 1'b1;
    bus.load = 1'b0; bus.load_val = '0; bus.limit = 4'd5; bus.periodic = 1'b0;
    cyc(2);
    total++; if (bus.count !== 4'd0) $display("FAIL reset_count got %0d exp 0", bus.count); else passed++;
    total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", bus.busy); else passed++;
    total++; if (bus.done !== 1'b0) $display("FAIL reset_done got %b exp 0", bus.done); else passed++;
    total++; if (bus.tc !== 1'b0) $display("FAIL reset_tc got %b exp 0", bus.tc); else passed++;
    reset = 1'b0; bus.start = 1'b0;
    cyc(2);
    total++; if (bus.count !== 4'd0 || bus.busy !== 1'b0) $display("FAIL idle_hold count %0d busy %b exp 0/0", bus.count, bus.busy); else passed++;
  endtask

  task automatic test_oneshot();
    bus.limit = 4'd5; bus.periodic = 1'b0; bus.up = 1'b1;
    bus.start = 1'b1; cyc(); bus.start = 1'b0;
    total++; if (bus.count !== 4'd0 || bus.busy !== 1'b1) $display("FAIL os_start count %0d busy %b exp 0/1", bus.count, bus.busy); else passed++;
    for (int k = 1; k <= 5; k++) begin
      cyc();
      total++; if (bus.count !== 4'(k) || bus.tc !== 1'b0) $display("FAIL os_step%0d count %0d tc %b exp %0d/0", k, bus.count, bus.tc, k); else passed++;
    end
    cyc();
    total++; if (bus.tc !== 1'b1 || bus.done !== 1'b1 || bus.busy !== 1'b0) $display("FAIL os_tc tc %b done %b busy %b exp 1/1/0", bus.tc, bus.done, bus.busy); else passed++;
    total++; if (bus.count !== 4'd5) $display("FAIL os_tc_count got %0d exp 5", bus.count); else passed++;
    cyc(2);
    total++; if (bus.tc !== 1'b0 || bus.count !== 4'd5 || bus.done !== 1'b1) $display("FAIL os_hold tc %b count %0d done %b exp 0/5/1", bus.tc, bus.count, bus.done); else passed++;
  endtask

  task automatic test_periodic();
    int exp_c[8];
    logic exp_t[8];
    exp_c = '{1, 2, 3, 0, 1, 2, 3, 0};
    exp_t = '{0, 0, 0, 1, 0, 0, 0, 1};
    bus.limit = 4'd3; bus.periodic = 1'b1; bus.up = 1'b1;
    bus.start = 1'b1; cyc(); bus.start = 1'b0;
    total++; if (bus.count !== 4'd0 || bus.busy !== 1'b1 || bus.done !== 1'b0) $display("FAIL per_start count %0d busy %b done %b exp 0/1/0", bus.count, bus.busy, bus.done); else passed++;
    for (int i = 0; i < 8; i++) begin
      cyc();
      total++; if (bus.count !== 4'(exp_c[i]) || bus.tc !== exp_t[i] || bus.busy !== 1'b1) $display("FAIL per_step%0d count %0d tc %b exp %0d/%b", i, bus.count, bus.tc, exp_c[i], exp_t[i]); else passed++;
    end
    bus.stop = 1'b1; cyc(); bus.stop = 1'b0;
    total++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.count !== 4'd0) $display("FAIL per_stop busy %b done %b count %0d exp 0/0/0", bus.busy, bus.done, bus.count); else passed++;
    cyc(2);
    total++; if (bus.count !== 4'd0 || bus.tc !== 1'b0) $display("FAIL idle_ignores_up count %0d tc %b exp 0/0", bus.count, bus.tc); else passed++;
  endtask

  task automatic test_load_wrap();
    int exp_c[4];
    exp_c = '{15, 0, 1, 2};
    bus.limit = 4'd2; bus.periodic = 1'b0; bus.up = 1'b1;
    bus.start = 1'b1; cyc(); bus.start = 1'b0;
    bus.load = 1'b1; bus.load_val = 4'd14; cyc(); bus.load = 1'b0;
    total++; if (bus.count !== 4'd14 || bus.busy !== 1'b1) $display("FAIL lw_load count %0d busy %b exp 14/1", bus.count, bus.busy); else passed++;
    for (int i = 0; i < 4; i++) begin
      cyc();
      total++; if (bus.count !== 4'(exp_c[i]) || bus.tc !== 1'b0) $display("FAIL lw_step%0d count %0d tc %b exp %0d/0", i, bus.count, bus.tc, exp_c[i]); else passed++;
    end
    cyc();
    total++; if (bus.tc !== 1'b1 || bus.done !== 1'b1 || bus.count !== 4'd2) $display("FAIL lw_tc tc %b done %b count %0d exp 1/1/2", bus.tc, bus.done, bus.count); else passed++;
  endtask

  task automatic test_collisions();
    bus.load_val = 4'd7; bus.load = 1'b1; bus.start = 1'b1; bus.up = 1'b1;
    cyc(); bus.load = 1'b0; bus.start = 1'b0;
    total++; if (bus.count !== 4'd7 || bus.done !== 1'b1 || bus.busy !== 1'b0) $display("FAIL col_load_start count %0d done %b busy %b exp 7/1/0", bus.count, bus.done, bus.busy); else passed++;
    bus.limit = 4'd2; bus.periodic = 1'b0;
    bus.start = 1'b1; cyc(); bus.start = 1'b0;
    cyc(2);
    total++; if (bus.count !== 4'd2 || bus.busy !== 1'b1) $display("FAIL col_at_limit count %0d busy %b exp 2/1", bus.count, bus.busy); else passed++;
    bus.stop = 1'b1; cyc(); bus.stop = 1'b0;
    total++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.tc !== 1'b0 || bus.count !== 4'd2) $display("FAIL col_stop busy %b done %b tc %b count %0d exp 0/0/0/2", bus.busy, bus.done, bus.tc, bus.count); else passed++;
    cyc();
    total++; if (bus.tc !== 1'b0) $display("FAIL col_stop_no_tc got %b exp 0", bus.tc); else passed++;
  endtask

  task automatic test_limit_zero_reset();
    bus.limit = 4'd0; bus.periodic = 1'b1; bus.up = 1'b1;
    bus.start = 1'b1; cyc(); bus.start = 1'b0;
    cyc();
    total++; if (bus.tc !== 1'b1 || bus.count !== 4'd0 || bus.busy !== 1'b1) $display("FAIL lim0_tc tc %b count %0d busy %b exp 1/0/1", bus.tc, bus.count, bus.busy); else passed++;
    reset = 1'b1; cyc(); reset = 1'b0;
    total++; if (bus.tc !== 1'b0 || bus.busy !== 1'b0 || bus.count !== 4'd0) $display("FAIL mid_reset tc %b busy %b count %0d exp 0/0/0", bus.tc, bus.busy, bus.count); else passed++;
  endtask

`ifdef PRESCALE_EN
  task automatic test_prescale();
    int exp_c;
    bus.limit = 4'd2; bus.periodic = 1'b0; bus.up = 1'b1;
    bus.start = 1'b1; cyc(); bus.start = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      if (e == 7) begin
        bus.up = 1'b0; cyc(3);
        total++; if (bus.count !== 4'd1 || bus.busy !== 1'b1) $display("FAIL ps_freeze count %0d busy %b exp 1/1", bus.count, bus.busy); else passed++;
        bus.up = 1'b1;
      end
      cyc();
      exp_c = (e < 12) ? e / 4 : 2;
      total++; if (bus.count !== 4'(exp_c) || bus.tc !== (e == 12) || bus.done !== (e == 12)) $display("FAIL ps_edge%0d count %0d tc %b done %b exp %0d/%b", e, bus.count, bus.tc, bus.done, exp_c, (e == 12)); else passed++;
    end
  endtask
`else
  task automatic test_freeze();
    bus.limit = 4'd5; bus.periodic = 1'b0; bus.up = 1'b1;
    bus.start = 1'b1; cyc(); bus.start = 1'b0;
    cyc(2);
    bus.up = 1'b0; cyc(3);
    total++; if (bus.count !== 4'd2 || bus.busy !== 1'b1) $display("FAIL freeze count %0d busy %b exp 2/1", bus.count, bus.busy); else passed++;
    bus.up = 1'b1; cyc();
    total++; if (bus.count !== 4'd3) $display("FAIL unfreeze count %0d exp 3", bus.count); else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_oneshot();
    test_periodic();
    test_load_wrap();
    test_collisions();
    test_limit_zero_reset();
`ifdef PRESCALE_EN
    test_prescale();
`else
    test_freeze();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
